// File: rtl/dvs_line_dma_sched.sv
// DVS line DMA scheduler: queues completed BRAM lines (ping-pong halves) and
// issues one CDMA descriptor at a time to copy each line into the frame buffer.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | no descriptor outstanding; issue when queue non-empty and enabled
//   S_ISSUE | desc_valid held with stable fields until desc_ready
//   S_WAIT  | descriptor accepted; waiting for xfer_done / xfer_err
module dvs_line_dma_sched #(
    parameter logic [31:0] BRAM_BASE  = 32'h4000_0000,
    parameter logic [31:0] DDR_BASE   = 32'h1000_0000,
    parameter int          LINE_BYTES = 320,
    parameter int          ROWS       = 240
) (
    input  logic        pclk,
    input  logic        reset,
    input  logic        enable,
    input  logic        new_frame,
    input  logic        write_new_line,
    input  logic        clr_status,
    output logic        desc_valid,
    input  logic        desc_ready,
    output logic [31:0] desc_src,
    output logic [31:0] desc_dst,
    output logic [15:0] desc_len,
    input  logic        xfer_done,
    input  logic        xfer_err,
    output logic [1:0]  pending,
    output logic [8:0]  row_idx,
    output logic [15:0] frame_cnt,
    output logic        busy,
    output logic        overflow,
    output logic        row_overrun,
    output logic        err_sticky,
    output logic        frame_done
);

    localparam logic [31:0] LINE_B   = 32'(LINE_BYTES);
    localparam logic [31:0] FRAME_B  = 32'(LINE_BYTES * ROWS);
    localparam logic [8:0]  ROWS_N   = 9'(ROWS);
    localparam logic [8:0]  ROW_LAST = 9'(ROWS - 1);
    localparam logic [15:0] LEN16    = 16'(LINE_BYTES);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t      state, state_nxt;
    logic        load_desc, pop, pop_err;
    logic        wr_half, fbuf;
    logic        q0_half, q0_fbuf, q1_half, q1_fbuf;
    logic [8:0]  q0_row, q1_row;
    logic [8:0]  row_eff;
    logic        half_eff, fbuf_eff, row_ok;
    logic        push, drop_ovf, drop_row;
    logic [31:0] head_src, head_dst;

    assign desc_valid = (state == S_ISSUE);
    assign busy       = (state != S_IDLE);

    // Next-state logic; pops happen only when the in-flight head completes
    always_comb begin
        state_nxt = state;
        load_desc = 1'b0;
        pop       = 1'b0;
        pop_err   = 1'b0;
        case (state)
            S_IDLE: begin
                if (enable && pending != 2'd0) begin
                    state_nxt = S_ISSUE;
                    load_desc = 1'b1;
                end
            end
            S_ISSUE: begin
                if (desc_ready) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (xfer_err) begin
                    pop       = 1'b1;
                    pop_err   = 1'b1;
                    state_nxt = S_IDLE;
                end else if (xfer_done) begin
                    pop       = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Line acceptance; a coincident new_frame is applied before the line
    always_comb begin
        row_eff  = new_frame ? 9'd0 : row_idx;
        half_eff = new_frame ? 1'b0 : wr_half;
        fbuf_eff = new_frame ? ~fbuf : fbuf;
        row_ok   = (row_eff < ROWS_N);
        push     = write_new_line && row_ok && (pending != 2'd2 || pop);
        drop_ovf = write_new_line && row_ok && pending == 2'd2 && !pop;
        drop_row = write_new_line && !row_ok;
        head_src = BRAM_BASE + (q0_half ? LINE_B : 32'd0);
        head_dst = DDR_BASE + (q0_fbuf ? FRAME_B : 32'd0) + 32'(q0_row) * LINE_B;
    end

    // FSM state register
    always_ff @(posedge pclk) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Descriptor fields captured from the queue head when leaving IDLE
    always_ff @(posedge pclk) begin
        if (!reset) begin
            desc_src <= 32'd0;
            desc_dst <= 32'd0;
            desc_len <= 16'd0;
        end else if (load_desc) begin
            desc_src <= head_src;
            desc_dst <= head_dst;
            desc_len <= LEN16;
        end
    end

    // Frame position tracking: row counter, BRAM write half, frame buffer
    always_ff @(posedge pclk) begin
        if (!reset) begin
            row_idx   <= 9'd0;
            wr_half   <= 1'b0;
            fbuf      <= 1'b0;
            frame_cnt <= 16'd0;
        end else begin
            if (new_frame) begin
                fbuf      <= ~fbuf;
                frame_cnt <= frame_cnt + 16'd1;
            end
            row_idx <= row_eff;
            wr_half <= half_eff;
            if (push) begin
                row_idx <= row_eff + 9'd1;
                wr_half <= ~half_eff;
            end else if (drop_ovf) begin
                row_idx <= row_eff + 9'd1;
            end
        end
    end

    // Two-entry queue, q0 is the head (and the in-flight entry while busy)
    always_ff @(posedge pclk) begin
        if (!reset) begin
            pending <= 2'd0;
            q0_half <= 1'b0;
            q0_row  <= 9'd0;
            q0_fbuf <= 1'b0;
            q1_half <= 1'b0;
            q1_row  <= 9'd0;
            q1_fbuf <= 1'b0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (pending == 2'd0) begin
                        q0_half <= half_eff;
                        q0_row  <= row_eff;
                        q0_fbuf <= fbuf_eff;
                    end else begin
                        q1_half <= half_eff;
                        q1_row  <= row_eff;
                        q1_fbuf <= fbuf_eff;
                    end
                    pending <= pending + 2'd1;
                end
                2'b01: begin
                    q0_half <= q1_half;
                    q0_row  <= q1_row;
                    q0_fbuf <= q1_fbuf;
                    pending <= pending - 2'd1;
                end
                2'b11: begin
                    if (pending == 2'd2) begin
                        q0_half <= q1_half;
                        q0_row  <= q1_row;
                        q0_fbuf <= q1_fbuf;
                        q1_half <= half_eff;
                        q1_row  <= row_eff;
                        q1_fbuf <= fbuf_eff;
                    end else begin
                        q0_half <= half_eff;
                        q0_row  <= row_eff;
                        q0_fbuf <= fbuf_eff;
                    end
                end
                default: ;
            endcase
        end
    end

    // Sticky status flags (set beats clear) and the frame-complete pulse
    always_ff @(posedge pclk) begin
        if (!reset) begin
            overflow    <= 1'b0;
            row_overrun <= 1'b0;
            err_sticky  <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            overflow    <= drop_ovf | (overflow & ~clr_status);
            row_overrun <= drop_row | (row_overrun & ~clr_status);
            err_sticky  <= pop_err | (err_sticky & ~clr_status);
            frame_done  <= pop && !pop_err && (q0_row == ROW_LAST);
        end
    end

endmodule

// File: tb/tb_dvs_line_dma_sched.sv
// Testbench for dvs_line_dma_sched: expected descriptors are queued when lines
// are issued; negedge monitors pop and compare on every accepted descriptor.
// A second instance with ROWS=4 covers end-of-frame and row overrun.
module tb_dvs_line_dma_sched;

    logic pclk = 1'b0;
    always #5 pclk = ~pclk;

    logic reset, reset4, enable, new_frame, write_new_line, clr_status;
    logic desc_ready, xfer_done, xfer_err;

    logic        desc_valid, busy, overflow, row_overrun, err_sticky, frame_done;
    logic [31:0] desc_src, desc_dst;
    logic [15:0] desc_len, frame_cnt;
    logic [1:0]  pending;
    logic [8:0]  row_idx;

    logic        desc_valid4, busy4, overflow4, row_overrun4, err_sticky4, frame_done4;
    logic [31:0] desc_src4, desc_dst4;
    logic [15:0] desc_len4, frame_cnt4;
    logic [1:0]  pending4;
    logic [8:0]  row_idx4;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int fd_cnt   = 0;
    int fd4_cnt  = 0;
    logic [79:0] exp_q[$];
    logic [79:0] exp_q4[$];

    dvs_line_dma_sched dut (
        .pclk(pclk), .reset(reset), .enable(enable), .new_frame(new_frame),
        .write_new_line(write_new_line), .clr_status(clr_status),
        .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_src(desc_src),
        .desc_dst(desc_dst), .desc_len(desc_len), .xfer_done(xfer_done),
        .xfer_err(xfer_err), .pending(pending), .row_idx(row_idx),
        .frame_cnt(frame_cnt), .busy(busy), .overflow(overflow),
        .row_overrun(row_overrun), .err_sticky(err_sticky), .frame_done(frame_done)
    );

    dvs_line_dma_sched #(.ROWS(4)) dut4 (
        .pclk(pclk), .reset(reset4), .enable(enable), .new_frame(new_frame),
        .write_new_line(write_new_line), .clr_status(clr_status),
        .desc_valid(desc_valid4), .desc_ready(desc_ready), .desc_src(desc_src4),
        .desc_dst(desc_dst4), .desc_len(desc_len4), .xfer_done(xfer_done),
        .xfer_err(xfer_err), .pending(pending4), .row_idx(row_idx4),
        .frame_cnt(frame_cnt4), .busy(busy4), .overflow(overflow4),
        .row_overrun(row_overrun4), .err_sticky(err_sticky4), .frame_done(frame_done4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor for the default instance
    always @(negedge pclk) begin
        logic [79:0] e;
        if (desc_valid && desc_ready) begin
            if (exp_q.size() == 0) begin
                chk_cnt++;
                $display("FAIL desc_unexpected: got src 0x%0h dst 0x%0h expected no descriptor", desc_src, desc_dst);
            end else begin
                e = exp_q.pop_front();
                chk("desc_src", desc_src, e[79:48]);
                chk("desc_dst", desc_dst, e[47:16]);
                chk("desc_len", 32'(desc_len), 32'(e[15:0]));
            end
        end
        if (frame_done) fd_cnt++;
    end

    // Monitor for the ROWS=4 instance
    always @(negedge pclk) begin
        logic [79:0] e;
        if (desc_valid4 && desc_ready) begin
            if (exp_q4.size() == 0) begin
                chk_cnt++;
                $display("FAIL desc4_unexpected: got src 0x%0h dst 0x%0h expected no descriptor", desc_src4, desc_dst4);
            end else begin
                e = exp_q4.pop_front();
                chk("desc4_src", desc_src4, e[79:48]);
                chk("desc4_dst", desc_dst4, e[47:16]);
                chk("desc4_len", 32'(desc_len4), 32'(e[15:0]));
            end
        end
        if (frame_done4) fd4_cnt++;
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic pulse_line(input logic nf);
        write_new_line = 1'b1;
        new_frame      = nf;
        tick();
        write_new_line = 1'b0;
        new_frame      = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0; reset4 = 1'b0; enable = 1'b0; new_frame = 1'b0;
        write_new_line = 1'b0; clr_status = 1'b0; desc_ready = 1'b0;
        xfer_done = 1'b0; xfer_err = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic wait_wait(input bit sel);
        int n;
        n = 0;
        while (!(sel ? (busy4 && !desc_valid4) : (busy && !desc_valid)) && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            chk_cnt++;
            $display("FAIL wait_timeout: got no WAIT state within 50 cycles expected WAIT");
        end
    endtask

    task automatic complete(input bit sel, input bit err);
        wait_wait(sel);
        xfer_done = 1'b1;
        xfer_err  = err;
        tick();
        xfer_done = 1'b0;
        xfer_err  = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        reset = 1'b0;
        tick();
        chk("rst_pending", 32'(pending), 0);
        chk("rst_row_idx", 32'(row_idx), 0);
        chk("rst_frame_cnt", 32'(frame_cnt), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_flags", {29'd0, overflow, row_overrun, err_sticky}, 0);
        chk("rst_desc_valid", 32'(desc_valid), 0);
        chk("rst_desc_src", desc_src, 0);
        chk("rst_desc_dst", desc_dst, 0);
        chk("rst_desc_len", 32'(desc_len), 0);
        chk("rst_frame_done", 32'(frame_done), 0);

        // First line of a new frame: latency and addressing into fbuf 1
        reset = 1'b1; enable = 1'b1; desc_ready = 1'b1;
        exp_q.push_back({32'h4000_0000, 32'h1001_2C00, 16'd320});
        pulse_line(1'b1);
        chk("a_valid_early", 32'(desc_valid), 0);
        chk("a_frame_cnt", 32'(frame_cnt), 1);
        tick();
        chk("a_valid_lat2", 32'(desc_valid), 1);
        complete(1'b0, 1'b0);
        chk("a_pending_done", 32'(pending), 0);
        chk("a_row_idx", 32'(row_idx), 1);

        // Overflow: three back-to-back lines with CDMA stalled
        do_reset();
        enable = 1'b1;
        exp_q.push_back({32'h4000_0000, 32'h1000_0000, 16'd320});
        exp_q.push_back({32'h4000_0140, 32'h1000_0140, 16'd320});
        pulse_line(1'b0);
        pulse_line(1'b0);
        pulse_line(1'b0);
        chk("b_pending_full", 32'(pending), 2);
        chk("b_overflow", 32'(overflow), 1);
        chk("b_row_idx", 32'(row_idx), 3);
        desc_ready = 1'b1;
        complete(1'b0, 1'b0);
        chk("b_pending_one", 32'(pending), 1);
        exp_q.push_back({32'h4000_0000, 32'h1000_03C0, 16'd320});
        pulse_line(1'b0);
        complete(1'b0, 1'b0);
        complete(1'b0, 1'b0);
        chk("b_pending_empty", 32'(pending), 0);
        chk("b_row_idx_end", 32'(row_idx), 4);
        chk("b_overflow_held", 32'(overflow), 1);
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        chk("b_overflow_clr", 32'(overflow), 0);

        // End of frame and row overrun on the ROWS=4 instance
        do_reset();
        reset = 1'b0;
        reset4 = 1'b1; enable = 1'b1; desc_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_q4.push_back({32'h4000_0000 + 32'(i % 2) * 32'd320,
                              32'h1000_0000 + 32'(i) * 32'd320, 16'd320});
            pulse_line(1'b0);
            complete(1'b1, 1'b0);
            tick();
            chk("c_frame_done_cnt", 32'(fd4_cnt), (i == 3) ? 32'd1 : 32'd0);
        end
        chk("c_row_idx", 32'(row_idx4), 4);
        chk("c_overrun_clear", 32'(row_overrun4), 0);
        pulse_line(1'b0);
        chk("c_overrun_set", 32'(row_overrun4), 1);
        chk("c_pending", 32'(pending4), 0);
        chk("c_row_idx_held", 32'(row_idx4), 4);
        tick();
        tick();
        chk("c_busy", 32'(busy4), 0);
        chk("c_frame_done_once", 32'(fd4_cnt), 1);

        // Error and done together: pop, sticky error, no frame_done
        do_reset();
        enable = 1'b1; desc_ready = 1'b1;
        exp_q.push_back({32'h4000_0000, 32'h1000_0000, 16'd320});
        pulse_line(1'b0);
        chk("d_pending_one", 32'(pending), 1);
        complete(1'b0, 1'b1);
        chk("d_pending_pop", 32'(pending), 0);
        chk("d_err_sticky", 32'(err_sticky), 1);
        tick();
        chk("d_no_frame_done", 32'(fd_cnt), 0);
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        chk("d_err_clr", 32'(err_sticky), 0);

        // new_frame coinciding with a line after one line of the old frame
        do_reset();
        enable = 1'b1;
        exp_q.push_back({32'h4000_0000, 32'h1000_0000, 16'd320});
        pulse_line(1'b0);
        exp_q.push_back({32'h4000_0000, 32'h1001_2C00, 16'd320});
        pulse_line(1'b1);
        chk("e_frame_cnt", 32'(frame_cnt), 1);
        chk("e_pending", 32'(pending), 2);
        chk("e_row_idx", 32'(row_idx), 1);
        chk("e_overflow", 32'(overflow), 0);
        desc_ready = 1'b1;
        complete(1'b0, 1'b0);
        complete(1'b0, 1'b0);
        chk("e_pending_empty", 32'(pending), 0);

        // enable=0 holds issue while lines still queue
        do_reset();
        desc_ready = 1'b1;
        exp_q.push_back({32'h4000_0000, 32'h1000_0000, 16'd320});
        pulse_line(1'b0);
        tick();
        tick();
        tick();
        chk("g_busy_disabled", 32'(busy), 0);
        chk("g_pending", 32'(pending), 1);
        enable = 1'b1;
        complete(1'b0, 1'b0);
        chk("g_pending_done", 32'(pending), 0);

        // Reset while waiting for completion
        do_reset();
        enable = 1'b1; desc_ready = 1'b1;
        exp_q.push_back({32'h4000_0000, 32'h1000_0000, 16'd320});
        pulse_line(1'b0);
        wait_wait(1'b0);
        reset = 1'b0;
        tick();
        chk("f_busy", 32'(busy), 0);
        chk("f_pending", 32'(pending), 0);
        chk("f_desc_valid", 32'(desc_valid), 0);
        chk("f_desc_src", desc_src, 0);
        chk("f_desc_dst", desc_dst, 0);
        chk("f_row_idx", 32'(row_idx), 0);
        reset = 1'b1;
        xfer_done = 1'b1;
        tick();
        xfer_done = 1'b0;
        chk("f_no_pop", 32'(pending), 0);
        chk("f_busy_after", 32'(busy), 0);

        tick();
        chk("end_exp_q_empty", 32'(exp_q.size()), 0);
        chk("end_exp_q4_empty", 32'(exp_q4.size()), 0);
        chk("end_no_frame_done", 32'(fd_cnt), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/dvs_line_dma_sched.md
DVS_LINE_DMA_SCHED -- requirements
Module: dvs_line_dma_sched

Interface
REQ-001 SHALL have parameter BRAM_BASE, default 32'h4000_0000, byte address of the line BRAM as seen by the CDMA.
REQ-002 SHALL have parameter DDR_BASE, default 32'h1000_0000, byte address of frame buffer 0.
REQ-003 SHALL have parameter LINE_BYTES, default 320, bytes per line (80 words x 4 pixels).
REQ-004 SHALL have parameter ROWS, default 240, lines per frame; FRAME_BYTES = LINE_BYTES*ROWS.
REQ-005 SHALL have port pclk, input, 1, sole clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-low reset; 0 = in reset.
REQ-007 SHALL have port enable, input, 1, 1 = descriptor issue allowed.
REQ-008 SHALL have port new_frame, input, 1, one-cycle frame-start pulse from the DVS datapath.
REQ-009 SHALL have port write_new_line, input, 1, one-cycle pulse: one line is complete in the current BRAM half.
REQ-010 SHALL have port clr_status, input, 1, pulse that clears sticky flags.
REQ-011 SHALL have ports desc_valid (output, 1), desc_ready (input, 1), desc_src (output, 32), desc_dst (output, 32), desc_len (output, 16): CDMA descriptor handshake.
REQ-012 SHALL have ports xfer_done (input, 1) and xfer_err (input, 1): one-cycle completion pulses from the CDMA.
REQ-013 SHALL have outputs pending (2), row_idx (9), frame_cnt (16), busy (1), overflow (1), row_overrun (1), err_sticky (1), frame_done (1).

Function
REQ-014 SHALL treat the BRAM as ping-pong: half h at BRAM_BASE + h*LINE_BYTES; wr_half toggles on each accepted line.
REQ-015 SHALL keep a 2-entry queue of {half, row, fbuf}; pending = occupancy (0..2).
REQ-016 SHALL accept a line when write_new_line=1, pending<2 or a pop occurs that cycle, and row_idx<ROWS; push, then row_idx+1, toggle wr_half.
REQ-017 SHALL drop a line when pending=2 and no pop occurs that cycle: set overflow, no push; row_idx still increments; wr_half unchanged.
REQ-018 SHALL drop a line when row_idx=ROWS: set row_overrun; row_idx, wr_half and queue unchanged.
REQ-019 SHALL, on new_frame: row_idx<=0, wr_half<=0, fbuf toggles, frame_cnt+1 (wraps mod 2^16); queued and in-flight entries are unaffected.
REQ-020 SHALL, when new_frame and write_new_line coincide, apply new_frame first, so the line is row 0, half 0 of the new fbuf.
REQ-021 SHALL, on coincident push and pop, leave pending unchanged.
REQ-022 SHALL implement FSM IDLE, ISSUE, WAIT; busy=1 outside IDLE.
REQ-023 SHALL, from IDLE with pending>0 and enable=1, go to ISSUE next edge; desc fields are registered from the queue head at that edge.
REQ-024 SHALL drive desc_src = BRAM_BASE+half*LINE_BYTES, desc_dst = DDR_BASE+fbuf*FRAME_BYTES+row*LINE_BYTES (32-bit, mod 2^32), desc_len = LINE_BYTES.
REQ-025 SHALL hold desc_valid=1 and all desc fields stable in ISSUE until desc_valid&desc_ready, then go to WAIT.
REQ-026 SHALL, in WAIT on xfer_done, pop the head, pulse frame_done for one cycle if head row = ROWS-1, and go to IDLE.
REQ-027 SHALL, in WAIT on xfer_err, set err_sticky, pop the head without frame_done, and go to IDLE; xfer_err wins over coincident xfer_done.
REQ-028 SHALL ignore xfer_done/xfer_err outside WAIT.
REQ-029 SHALL, with enable=0, still accept pushes; no new ISSUE entry; an ISSUE or WAIT in progress completes.
REQ-030 SHALL clear overflow, row_overrun and err_sticky on clr_status; a set event in the same cycle wins.
REQ-031 SHALL have a latency of 2 cycles from write_new_line sampled in IDLE with an empty queue to desc_valid=1.

Reset
REQ-032 SHALL, while reset=0 at an edge: FSM=IDLE, queue empty, pending=0, row_idx=0, wr_half=0, fbuf=0, frame_cnt=0, all flags 0, desc_valid=0, desc_src=desc_dst=0, desc_len=0, frame_done=0.
REQ-033 SHALL abandon any ISSUE/WAIT on reset mid-operation; a later xfer_done is ignored.

Verification
REQ-034 Reset, enable=1, new_frame, write_new_line, desc_ready=1 -> desc_valid at +2 cycles; src 0x4000_0000, dst 0x1001_2C00 (fbuf=1), len 320.
REQ-035 Three back-to-back write_new_line, desc_ready=0 -> pending=2, overflow=1; the third line is dropped; row_idx=3; the next accepted line has dst row 3.
REQ-036 ROWS=4, 4 lines with completions -> frame_done pulses exactly once, after the row-3 xfer_done; the fifth line sets row_overrun.
REQ-037 xfer_err and xfer_done together in WAIT -> err_sticky=1, pending decrements, no frame_done; clr_status clears err_sticky.
REQ-038 new_frame and write_new_line in the same cycle -> the queued entry has row 0, half 0, and the toggled fbuf; frame_cnt+1.
REQ-039 reset=0 during WAIT -> all outputs at reset values next cycle; a following xfer_done causes no pop.
